// File: rtl/time_set_controller.sv
// Keypad time-setting session: collects HH, MM, SS digit pairs, range-checks each field on '#'
// and commits all three together; load pulses 1 cycle after the final '#'; no backpressure, keys arrive as strobes.
module time_set_controller #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_req,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       hour_en,
  output logic       min_en,
  output logic       sec_en,
  output logic       busy,
  output logic       load,
  output logic [4:0] hour_val,
  output logic [5:0] min_val,
  output logic [5:0] sec_val,
  output logic       err,
  output logic       abort
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  KEY_STAR = 4'd10;
  localparam logic [3:0]  KEY_HASH = 4'd11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOUR = 3'd1,
    MIN  = 3'd2,
    SEC  = 3'd3,
    LOAD = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  hour_sh_q, hour_sh_d;
  logic [5:0]  min_sh_q, min_sh_d;
  logic [4:0]  hour_val_d;
  logic [5:0]  min_val_d;
  logic [5:0]  sec_val_d;
  logic        load_d;
  logic        err_d;
  logic        abort_d;

  logic [6:0]  field_val;
  logic        field_ok;
  logic        is_digit;
  logic        timeout;

  always_comb begin
    field_val = 7'(tens_q) * 7'd10 + 7'(ones_q);
    field_ok  = (state_q == HOUR) ? (field_val <= 7'd23) : (field_val <= 7'd59);
    is_digit  = (key_code <= 4'd9);
    timeout   = !key_valid && (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    cnt_d      = cnt_q;
    hour_sh_d  = hour_sh_q;
    min_sh_d   = min_sh_q;
    hour_val_d = hour_val;
    min_val_d  = min_val;
    sec_val_d  = sec_val;
    load_d     = 1'b0;
    err_d      = 1'b0;
    abort_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (set_req) begin
          state_d = HOUR;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          cnt_d   = 16'd0;
        end
      end

      HOUR, MIN, SEC: begin
        if (key_valid) begin
          cnt_d = 16'd0;
          if (is_digit) begin
            tens_d = ones_q;
            ones_d = key_code;
          end else if (key_code == KEY_STAR) begin
            state_d   = IDLE;
            abort_d   = 1'b1;
            tens_d    = 4'd0;
            ones_d    = 4'd0;
            hour_sh_d = 5'd0;
            min_sh_d  = 6'd0;
          end else if (key_code == KEY_HASH) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
            if (!field_ok) begin
              err_d = 1'b1;
            end else if (state_q == HOUR) begin
              hour_sh_d = field_val[4:0];
              state_d   = MIN;
            end else if (state_q == MIN) begin
              min_sh_d = field_val[5:0];
              state_d  = SEC;
            end else begin
              // Seconds go straight to the output so the commit lands on the LOAD cycle itself.
              state_d    = LOAD;
              hour_val_d = hour_sh_q;
              min_val_d  = min_sh_q;
              sec_val_d  = field_val[5:0];
              load_d     = 1'b1;
            end
          end
        end else if (timeout) begin
          state_d   = IDLE;
          abort_d   = 1'b1;
          tens_d    = 4'd0;
          ones_d    = 4'd0;
          hour_sh_d = 5'd0;
          min_sh_d  = 6'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      LOAD: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      cnt_q     <= 16'd0;
      hour_sh_q <= 5'd0;
      min_sh_q  <= 6'd0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      cnt_q     <= cnt_d;
      hour_sh_q <= hour_sh_d;
      min_sh_q  <= min_sh_d;
    end
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hour_en  <= 1'b0;
      min_en   <= 1'b0;
      sec_en   <= 1'b0;
      busy     <= 1'b0;
      load     <= 1'b0;
      err      <= 1'b0;
      abort    <= 1'b0;
      hour_val <= 5'd0;
      min_val  <= 6'd0;
      sec_val  <= 6'd0;
    end else begin
      hour_en  <= (state_d == HOUR);
      min_en   <= (state_d == MIN);
      sec_en   <= (state_d == SEC);
      busy     <= (state_d != IDLE);
      load     <= load_d;
      err      <= err_d;
      abort    <= abort_d;
      hour_val <= hour_val_d;
      min_val  <= min_val_d;
      sec_val  <= sec_val_d;
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with a queue of expected output snapshots.
module tb_time_set_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       set_req = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       hour_en, min_en, sec_en, busy, load, err, abort;
  logic [4:0] hour_val;
  logic [5:0] min_val, sec_val;

  time_set_controller #(.TIMEOUT_CYC(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .set_req   (set_req),
    .key_valid (key_valid),
    .key_code  (key_code),
    .hour_en   (hour_en),
    .min_en    (min_en),
    .sec_en    (sec_en),
    .busy      (busy),
    .load      (load),
    .hour_val  (hour_val),
    .min_val   (min_val),
    .sec_val   (sec_val),
    .err       (err),
    .abort     (abort)
  );

  always #5 clock = ~clock;

  // flags = {hour_en, min_en, sec_en, busy, load, err, abort}
  typedef struct packed {
    logic [6:0] flags;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } obs_t;

  localparam logic [6:0] F_IDLE  = 7'b0000000;
  localparam logic [6:0] F_HOUR  = 7'b1001000;
  localparam logic [6:0] F_MIN   = 7'b0101000;
  localparam logic [6:0] F_SEC   = 7'b0011000;
  localparam logic [6:0] F_LOAD  = 7'b0001100;
  localparam logic [6:0] F_HERR  = 7'b1001010;
  localparam logic [6:0] F_MERR  = 7'b0101010;
  localparam logic [6:0] F_ABORT = 7'b0000001;
  localparam logic [3:0] STAR = 4'd10;
  localparam logic [3:0] HASH = 4'd11;

  obs_t       exp_q[$];
  logic [4:0] exp_h = 5'd0;
  logic [5:0] exp_m = 6'd0;
  logic [5:0] exp_s = 6'd0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string tag);
    obs_t e;
    obs_t o;
    e = exp_q.pop_front();
    o = '{flags: {hour_en, min_en, sec_en, busy, load, err, abort},
          h: hour_val, m: min_val, s: sec_val};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic expect_now(input logic [6:0] fl, input string tag);
    exp_q.push_back('{flags: fl, h: exp_h, m: exp_m, s: exp_s});
    check(tag);
  endtask

  task automatic step(input logic sr, input logic kv, input logic [3:0] kc,
                      input logic [6:0] fl, input string tag);
    set_req   = sr;
    key_valid = kv;
    key_code  = kc;
    exp_q.push_back('{flags: fl, h: exp_h, m: exp_m, s: exp_s});
    @(posedge clock);
    #1;
    set_req   = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    check(tag);
  endtask

  task automatic key(input logic [3:0] kc, input logic [6:0] fl, input string tag);
    step(1'b0, 1'b1, kc, fl, tag);
  endtask

  task automatic idle(input logic [6:0] fl, input string tag);
    step(1'b0, 1'b0, 4'd0, fl, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    expect_now(F_IDLE, "reset_state");
    reset = 1'b1;
    idle(F_IDLE, "post_reset_idle");

    // 14:30:05 full session
    step(1'b1, 1'b0, 4'd0, F_HOUR, "s1_start");
    key(4'd1, F_HOUR, "s1_h1");
    key(4'd4, F_HOUR, "s1_h4");
    key(HASH, F_MIN,  "s1_hash_h");
    key(4'd3, F_MIN,  "s1_m3");
    key(4'd0, F_MIN,  "s1_m0");
    key(HASH, F_SEC,  "s1_hash_m");
    key(4'd0, F_SEC,  "s1_s0");
    key(4'd5, F_SEC,  "s1_s5");
    exp_h = 5'd14; exp_m = 6'd30; exp_s = 6'd5;
    key(HASH, F_LOAD, "s1_load");
    idle(F_IDLE, "s1_load_one_cycle");

    // Cancel keeps committed values
    step(1'b1, 1'b0, 4'd0, F_HOUR, "s2_start");
    key(4'd0, F_HOUR,  "s2_h0");
    key(4'd9, F_HOUR,  "s2_h9");
    key(HASH, F_MIN,   "s2_hash_h");
    key(STAR, F_ABORT, "s2_cancel");
    idle(F_IDLE, "s2_abort_one_cycle");

    // Key alongside set_req is discarded; set_req ignored while busy
    step(1'b1, 1'b1, 4'd4, F_HOUR, "s3_start_with_key");
    key(4'd2, F_HOUR, "s3_h2");
    key(HASH, F_MIN,  "s3_hash_h_02");
    step(1'b1, 1'b0, 4'd0, F_MIN, "s3_setreq_ignored");
    key(STAR, F_ABORT, "s3_cancel");
    idle(F_IDLE, "s3_idle");

    // Range errors and last-two-digit retention
    step(1'b1, 1'b0, 4'd0, F_HOUR, "s4_start");
    key(4'd2, F_HOUR, "s4_h2");
    key(4'd5, F_HOUR, "s4_h5");
    key(HASH, F_HERR, "s4_err_25");
    key(4'd2, F_HOUR, "s4_err_one_cycle");
    key(4'd3, F_HOUR, "s4_h3");
    key(HASH, F_MIN,  "s4_hash_23");
    key(4'd6, F_MIN,  "s4_m6");
    key(4'd0, F_MIN,  "s4_m0");
    key(HASH, F_MERR, "s4_err_60");
    key(4'd1, F_MIN,  "s4_m1");
    key(4'd2, F_MIN,  "s4_m2");
    key(4'd3, F_MIN,  "s4_m3");
    key(HASH, F_SEC,  "s4_hash_123");
    key(4'd5,  F_SEC, "s4_s5");
    key(4'd12, F_SEC, "s4_unused_key");
    key(4'd9,  F_SEC, "s4_s9");
    exp_h = 5'd23; exp_m = 6'd23; exp_s = 6'd59;
    key(HASH, F_LOAD, "s4_load");
    idle(F_IDLE, "s4_idle");

    // Timeout after 8 idle cycles in SEC
    step(1'b1, 1'b0, 4'd0, F_HOUR, "s5_start");
    key(HASH, F_MIN, "s5_hash_h");
    key(HASH, F_SEC, "s5_hash_m");
    for (int i = 1; i <= 7; i++) idle(F_SEC, "s5_wait");
    idle(F_ABORT, "s5_timeout");
    idle(F_IDLE, "s5_idle");

    // Key on the expiry cycle wins and restarts the count
    step(1'b1, 1'b0, 4'd0, F_HOUR, "s6_start");
    key(HASH, F_MIN, "s6_hash_h");
    key(HASH, F_SEC, "s6_hash_m");
    for (int i = 1; i <= 7; i++) idle(F_SEC, "s6_wait");
    key(4'd13, F_SEC, "s6_key_at_expiry");
    for (int i = 1; i <= 7; i++) idle(F_SEC, "s6_wait2");
    idle(F_ABORT, "s6_timeout2");

    // Asynchronous reset mid-session
    step(1'b1, 1'b0, 4'd0, F_HOUR, "s7_start");
    key(HASH, F_MIN, "s7_hash_h");
    key(4'd1, F_MIN, "s7_m1");
    #2;
    reset = 1'b0;
    #1;
    exp_h = 5'd0; exp_m = 6'd0; exp_s = 6'd0;
    expect_now(F_IDLE, "s7_async_reset");
    @(posedge clock);
    #1;
    expect_now(F_IDLE, "s7_reset_no_load");
    reset = 1'b1;
    step(1'b1, 1'b0, 4'd0, F_HOUR, "s7_restart");

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_residue observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
